// File: rtl/c3lib_demux2_pkg.sv
// Shared types and constants for the 1-to-2 sequential demultiplexer.
package c3lib_demux2_pkg;

  localparam int unsigned LANE_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  typedef logic [CNT_W-1:0] cnt_t;

  // A lane can take another beat while it holds fewer than LANE_DEPTH entries.
  function automatic logic lane_has_room(input cnt_t cnt);
    return (cnt < cnt_t'(LANE_DEPTH));
  endfunction

endpackage : c3lib_demux2_pkg

// File: rtl/c3lib_demux2_lane_buf.sv
// Two-entry registered lane buffer; entry0 is always the head presented downstream.
module c3lib_demux2_lane_buf
  import c3lib_demux2_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head,
  output logic             head_vld,
  output cnt_t             count
);

  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  cnt_t             count_q,  count_d;
  logic             push_ok_c;
  logic             pop_c;

  assign head     = entry0_q;
  assign head_vld = (count_q != cnt_t'(0));
  assign count    = count_q;

  always_comb begin
    push_ok_c = push & lane_has_room(count_q);
    pop_c     = head_vld & pop_rdy;
  end

  // Push lands in the first free slot; pop shifts entry1 forward. A push+pop
  // can only occur with one entry held, so the new beat replaces the head.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    unique case ({push_ok_c, pop_c})
      2'b10: begin
        if (count_q == cnt_t'(0)) begin
          entry0_d = push_data;
        end else begin
          entry1_d = push_data;
        end
        count_d = cnt_t'(count_q + cnt_t'(1));
      end
      2'b01: begin
        if (count_q == cnt_t'(LANE_DEPTH)) begin
          entry0_d = entry1_q;
        end
        count_d = cnt_t'(count_q - cnt_t'(1));
      end
      2'b11: begin
        entry0_d = push_data;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= '0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

endmodule : c3lib_demux2_lane_buf

// File: rtl/c3lib_demux2_svt_seq.sv
// Sequential 1-to-2 demux: steers input beats to two buffered lanes by explicit
// select or by automatic alternation, undoing a 2:1 time-multiplexed stream.
module c3lib_demux2_svt_seq
  import c3lib_demux2_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             auto_mode,
  input  logic             resync,
  input  logic             sel,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  output logic             din_rdy,
  output logic [WIDTH-1:0] dout0,
  output logic             dout0_vld,
  input  logic             dout0_rdy,
  output logic [WIDTH-1:0] dout1,
  output logic             dout1_vld,
  input  logic             dout1_rdy
);

  lane_e ptr_q, ptr_d;
  lane_e dst_c;
  cnt_t  count0, count1;
  logic  accept_c;
  logic  push0_c, push1_c;

  // Destination lane and input readiness depend only on registered lane state.
  always_comb begin
    dst_c    = auto_mode ? ptr_q : lane_e'(sel);
    din_rdy  = (dst_c == LANE0) ? lane_has_room(count0) : lane_has_room(count1);
    accept_c = din_vld & din_rdy;
    push0_c  = accept_c & (dst_c == LANE0);
    push1_c  = accept_c & (dst_c == LANE1);
  end

  // Resync wins over toggling; in explicit mode the pointer is frozen.
  always_comb begin
    ptr_d = ptr_q;
    if (auto_mode) begin
      if (resync) begin
        ptr_d = LANE0;
      end else if (accept_c) begin
        ptr_d = lane_e'(~ptr_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= LANE0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  c3lib_demux2_lane_buf #(.WIDTH(WIDTH)) u_lane0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0_c),
    .push_data (din),
    .pop_rdy   (dout0_rdy),
    .head      (dout0),
    .head_vld  (dout0_vld),
    .count     (count0)
  );

  c3lib_demux2_lane_buf #(.WIDTH(WIDTH)) u_lane1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1_c),
    .push_data (din),
    .pop_rdy   (dout1_rdy),
    .head      (dout1),
    .head_vld  (dout1_vld),
    .count     (count1)
  );

`ifndef SYNTHESIS
  // An unknown explicit select would silently pick a lane in silicon.
  always_ff @(posedge clk) begin
    if (!rst && din_vld && !auto_mode) begin
      assert (!$isunknown(sel))
        else $error("c3lib_demux2_svt_seq: sel unknown while din_vld=1 in explicit mode");
    end
  end
`endif

endmodule : c3lib_demux2_svt_seq

// File: tb/tb_c3lib_demux2_svt_seq.sv
// Directed bench for c3lib_demux2_svt_seq with hand-computed expectations.
module tb_c3lib_demux2_svt_seq;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             auto_mode;
  logic             resync;
  logic             sel;
  logic [WIDTH-1:0] din;
  logic             din_vld;
  logic             din_rdy;
  logic [WIDTH-1:0] dout0;
  logic             dout0_vld;
  logic             dout0_rdy;
  logic [WIDTH-1:0] dout1;
  logic             dout1_vld;
  logic             dout1_rdy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  c3lib_demux2_svt_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .auto_mode (auto_mode),
    .resync    (resync),
    .sel       (sel),
    .din       (din),
    .din_vld   (din_vld),
    .din_rdy   (din_rdy),
    .dout0     (dout0),
    .dout0_vld (dout0_vld),
    .dout0_rdy (dout0_rdy),
    .dout1     (dout1),
    .dout1_vld (dout1_vld),
    .dout1_rdy (dout1_rdy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; auto_mode = 1'b0; resync = 1'b0; sel = 1'b0;
    din = '0; din_vld = 1'b0; dout0_rdy = 1'b1; dout1_rdy = 1'b1;
    cyc(); cyc(); cyc();
    rst = 1'b0;
    settle();
    chk("rst_vld0", 16'(dout0_vld), 16'h0);
    chk("rst_vld1", 16'(dout1_vld), 16'h0);
    chk("rst_dout0", 16'(dout0), 16'h0);
    chk("rst_dout1", 16'(dout1), 16'h0);
    chk("rst_din_rdy", 16'(din_rdy), 16'h1);

    // Auto alternation, both lanes draining every cycle.
    auto_mode = 1'b1; din_vld = 1'b1; din = 8'h10;
    cyc();
    chk("alt_d0_10", 16'(dout0), 16'h10);
    chk("alt_v0_10", 16'(dout0_vld), 16'h1);
    chk("alt_v1_10", 16'(dout1_vld), 16'h0);
    din = 8'h11;
    cyc();
    chk("alt_d1_11", 16'(dout1), 16'h11);
    chk("alt_v1_11", 16'(dout1_vld), 16'h1);
    chk("alt_v0_11", 16'(dout0_vld), 16'h0);
    chk("alt_d0_hold", 16'(dout0), 16'h10);
    din = 8'h12;
    cyc();
    chk("alt_d0_12", 16'(dout0), 16'h12);
    chk("alt_v0_12", 16'(dout0_vld), 16'h1);
    chk("alt_v1_12", 16'(dout1_vld), 16'h0);
    din = 8'h13;
    cyc();
    chk("alt_d1_13", 16'(dout1), 16'h13);
    chk("alt_v1_13", 16'(dout1_vld), 16'h1);
    chk("alt_v0_13", 16'(dout0_vld), 16'h0);
    din_vld = 1'b0;
    cyc();
    chk("alt_idle_v0", 16'(dout0_vld), 16'h0);
    chk("alt_idle_v1", 16'(dout1_vld), 16'h0);
    chk("alt_idle_d1", 16'(dout1), 16'h13);

    // Resync coincident with a beat: beat to lane 1, next beat back to lane 0.
    din_vld = 1'b1; din = 8'hA0;
    cyc();
    chk("rs_d0_a0", 16'(dout0), 16'hA0);
    din = 8'hA1; resync = 1'b1;
    cyc();
    chk("rs_d1_a1", 16'(dout1), 16'hA1);
    chk("rs_v1_a1", 16'(dout1_vld), 16'h1);
    resync = 1'b0; din = 8'hA2;
    cyc();
    chk("rs_d0_a2", 16'(dout0), 16'hA2);
    chk("rs_v0_a2", 16'(dout0_vld), 16'h1);
    chk("rs_v1_a2", 16'(dout1_vld), 16'h0);
    // Resync alone (pointer currently at lane 1) forces lane 0.
    din_vld = 1'b0; resync = 1'b1;
    cyc();
    resync = 1'b0; din_vld = 1'b1; din = 8'hB0;
    cyc();
    chk("rs_only_d0", 16'(dout0), 16'hB0);
    chk("rs_only_v0", 16'(dout0_vld), 16'h1);
    chk("rs_only_v1", 16'(dout1_vld), 16'h0);
    din_vld = 1'b0;
    cyc();

    // Explicit select to lane 1 with backpressure.
    auto_mode = 1'b0; sel = 1'b1; dout1_rdy = 1'b0;
    din_vld = 1'b1; din = 8'h01;
    settle();
    chk("bp_rdy_empty", 16'(din_rdy), 16'h1);
    cyc();
    chk("bp_d1_01", 16'(dout1), 16'h01);
    din = 8'h02;
    cyc();
    chk("bp_d1_head", 16'(dout1), 16'h01);
    din = 8'h03;
    settle();
    chk("bp_rdy_full", 16'(din_rdy), 16'h0);
    cyc();
    chk("bp_rdy_still", 16'(din_rdy), 16'h0);
    chk("bp_v0_never", 16'(dout0_vld), 16'h0);

    // Lane 1 stalled full; lane 0 runs at full rate.
    sel = 1'b0; din = 8'h55;
    settle();
    chk("ind_rdy", 16'(din_rdy), 16'h1);
    cyc();
    chk("ind_d0_55", 16'(dout0), 16'h55);
    chk("ind_v0_55", 16'(dout0_vld), 16'h1);
    din = 8'h56;
    cyc();
    chk("ind_d0_56", 16'(dout0), 16'h56);
    chk("ind_d1_stall", 16'(dout1), 16'h01);
    chk("ind_v1_stall", 16'(dout1_vld), 16'h1);

    // Release lane 1: din_rdy ignores downstream rdy in the same cycle.
    sel = 1'b1; din = 8'h03; dout1_rdy = 1'b1;
    settle();
    chk("rel_rdy_nopass", 16'(din_rdy), 16'h0);
    cyc();
    chk("rel_d1_02", 16'(dout1), 16'h02);
    chk("rel_rdy_after", 16'(din_rdy), 16'h1);
    chk("rel_v0_drained", 16'(dout0_vld), 16'h0);
    cyc();
    chk("rel_d1_03", 16'(dout1), 16'h03);
    din_vld = 1'b0;
    cyc();
    chk("rel_v1_empty", 16'(dout1_vld), 16'h0);

    // Push and pop together on a 1-entry lane.
    sel = 1'b0; dout0_rdy = 1'b0; din_vld = 1'b1; din = 8'h66;
    cyc();
    chk("pp_d0_66", 16'(dout0), 16'h66);
    dout0_rdy = 1'b1; din = 8'h77;
    cyc();
    chk("pp_d0_77", 16'(dout0), 16'h77);
    chk("pp_v0_77", 16'(dout0_vld), 16'h1);
    din_vld = 1'b0; dout0_rdy = 1'b0;
    cyc();
    chk("pp_cnt1_v0", 16'(dout0_vld), 16'h1);
    dout0_rdy = 1'b1;
    cyc();
    chk("pp_cnt1_empty", 16'(dout0_vld), 16'h0);

    // Resync ignored in explicit mode; auto mode resumes from held pointer (lane 1).
    resync = 1'b1;
    cyc();
    resync = 1'b0; auto_mode = 1'b1; din_vld = 1'b1; din = 8'hC0;
    cyc();
    chk("sw_d1_c0", 16'(dout1), 16'hC0);
    chk("sw_v1_c0", 16'(dout1_vld), 16'h1);
    chk("sw_v0_c0", 16'(dout0_vld), 16'h0);

    // Fill lanes in auto mode until lane 0 is full, then reset mid-traffic.
    dout0_rdy = 1'b0; dout1_rdy = 1'b0; din = 8'hD0;
    cyc();
    din = 8'hD1;
    cyc();
    din = 8'hD2;
    cyc();
    din = 8'hD3;
    settle();
    chk("stall_auto_rdy", 16'(din_rdy), 16'h0);
    chk("stall_d0_head", 16'(dout0), 16'hD0);
    chk("stall_d1_head", 16'(dout1), 16'hC0);
    rst = 1'b1;
    cyc(); cyc(); cyc();
    rst = 1'b0; din_vld = 1'b0; dout0_rdy = 1'b1; dout1_rdy = 1'b1;
    settle();
    chk("mrst_v0", 16'(dout0_vld), 16'h0);
    chk("mrst_v1", 16'(dout1_vld), 16'h0);
    chk("mrst_d0", 16'(dout0), 16'h0);
    chk("mrst_d1", 16'(dout1), 16'h0);
    chk("mrst_rdy", 16'(din_rdy), 16'h1);
    cyc();
    chk("mrst_no_stale0", 16'(dout0_vld), 16'h0);
    chk("mrst_no_stale1", 16'(dout1_vld), 16'h0);
    din_vld = 1'b1; din = 8'hF0;
    cyc();
    chk("mrst_ptr0_d0", 16'(dout0), 16'hF0);
    chk("mrst_ptr0_v0", 16'(dout0_vld), 16'h1);
    din_vld = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_c3lib_demux2_svt_seq

// File: doc/c3lib_demux2_svt_seq.md
# c3lib_demux2_svt_seq

Sequential 1-to-2 demultiplexer: the receive-side counterpart of the 2-to-1 mux primitive. Steers a single input beat stream onto two output lanes, either by an explicit select or by automatic alternation, which undoes a 2:1 time-multiplexed stream. Each lane has a 2-entry registered buffer with a valid/ready handshake. Sits in the c3lib common library, directly after a 2:1 serializing mux path, in a single clock domain.

## Interface
- WIDTH, 8, data width of input and each output lane
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- auto_mode  input  1  1: lane alternates per accepted beat; 0: lane = sel
- resync  input  1  single-cycle pulse; auto mode only; forces next destination to lane 0
- sel  input  1  explicit destination lane, used only when auto_mode=0
- din  input  WIDTH  input beat
- din_vld  input  1  input beat valid
- din_rdy  output  1  block can accept a beat for the current destination lane
- dout0 / dout1  output  WIDTH  head entry of lane 0 / lane 1 buffer
- dout0_vld / dout1_vld  output  1  lane head valid
- dout0_rdy / dout1_rdy  input  1  downstream consumes lane head

## Operation
- Destination lane dst: auto_mode=0 gives dst=sel; auto_mode=1 gives dst=ptr (internal 1-bit register).
- Beat accepted when din_vld & din_rdy; written to the tail of lane dst.
- din_rdy = (count[dst] < 2); depends on registered lane state and dst only, not on doutX_rdy (no same-cycle pass-through).
- Lane pop when doutX_vld & doutX_rdy; push and pop in the same cycle on a full lane are impossible (rdy low); on a 1-entry lane both occur, count stays 1, and the new beat becomes the head.
- doutX = head entry register; doutX_vld = (count[X] != 0).
- ptr update (auto_mode=1): resync=1 gives ptr<=0 (overrides everything); else an accepted beat gives ptr<=~ptr; else hold.
- resync coincident with an accepted beat: beat goes to the current ptr lane, then ptr<=0.
- auto_mode=0: ptr holds its value; resync ignored.
- auto_mode switching 0->1 resumes from the held ptr.
- sel=X/Z while din_vld=1 and auto_mode=0: simulation assertion error; no defined RTL behaviour.
- Lanes are independent: a stalled lane blocks input only while dst points to it; in auto mode this stalls the whole stream (ordering preserved).

## Timing
- Reset (rst=1 at edge): ptr=0, both counts=0, entries=0; thus dout0=dout1=0, dout0_vld=dout1_vld=0, din_rdy=1 the cycle after reset.
- Reset mid-operation discards all buffered beats; no partial output.
- Latency: beat accepted at edge N appears on doutX with doutX_vld=1 after edge N (visible cycle N+1).
- Throughput: 1 beat/cycle into the input; each lane sustains 1 beat/cycle when its rdy is held high.
- Full: count=2 gives din_rdy=0 for that lane; it reasserts the cycle after a pop.
- Empty: count=0 gives doutX_vld=0; doutX holds its last value (not zeroed).

## Structure
- Package c3lib_demux2_pkg: LANE_DEPTH=2, lane index typedef (LANE0=1'b0, LANE1=1'b1), count typedef (2 bits).
- Sub-module c3lib_demux2_lane_buf: 2-entry FIFO with push/pop, count, head output; instantiated twice.
- Top holds ptr, dst decode, din_rdy mux, and push steering.

## Test plan
- Reset: hold rst 3 cycles mid-traffic -> all vld=0, dout=0, din_rdy=1 next cycle; pre-reset data never appears.
- Auto alternation: auto_mode=1, both rdy=1, din=0x10,0x11,0x12,0x13 back-to-back -> dout0 gets 0x10,0x12; dout1 gets 0x11,0x13; each 1 cycle after acceptance.
- Resync: auto_mode=1, send 0xA0 (lane 0), then 0xA1 with resync=1 same cycle -> 0xA1 on lane 1; next beat 0xA2 on lane 0.
- Explicit select + backpressure: auto_mode=0, sel=1, dout1_rdy=0, send 0x01,0x02,0x03 -> first two buffered, din_rdy=0 on the third; raise dout1_rdy -> 0x01,0x02,0x03 in order; lane 0 never valid.
- Independent lanes: lane 1 full, switch sel=0 -> din_rdy=1 and lane 0 accepts 0x55 at full rate while lane 1 is stalled.
- Push/pop on a 1-entry lane: count=1, simultaneous pop and push of 0x77 -> count stays 1, dout shows 0x77 the next cycle.
